uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

- Transmit-side controller for the POV serial link.
- Owns the baud-period counter and uses it to sequence 8-bit UART frames (start, 8 data LSB-first, optional parity, stop) onto one `tx` line.
- Shares that line between two byte requesters with round-robin arbitration.
- Sits between the display/status logic that produces bytes and the FPGA TX pin.

## Interface
Parameters:
- `PERIOD`, 5208: clk cycles per bit (9600 baud at 50 MHz); minimum 2.
- `CNT_W`, 13: baud counter width; must satisfy 2^CNT_W > PERIOD.

Ports:
- `clk`  input  1  system clock.
- `Reset`  input  1  reset Reset, synchronous, active-high; clock clk.
- `data0`  input  8  byte from requester 0.
- `valid0`  input  1  requester 0 holds a byte.
- `ready0`  output  1  scheduler accepts requester 0 this cycle.
- `data1`  input  8  byte from requester 1.
- `valid1`  input  1  requester 1 holds a byte.
- `ready1`  output  1  scheduler accepts requester 1 this cycle.
- `tx`  output  1  serial line, idle high.
- `busy`  output  1  frame in progress (state != IDLE).
- `grant_id`  output  1  requester owning the current or most recent frame.

## Operation
- **State machine:** IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- **Baud counter** (`CNT_W` bits):
  - Held at 0 in IDLE.
  - In any other state it counts 0..PERIOD-1; the terminal count `PERIOD-1` is the bit-end tick, and the counter wraps to 0 on the tick.
- **Arbitration:** combinational, evaluated in IDLE only.
  - One valid: that requester is granted.
  - Both valid: the requester that is not `last_grant` is granted.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
- **Ready:** `readyN = (state==IDLE) && validN && granted==N`. At most one ready is high in a cycle; ready is never high outside IDLE.
- **Transfer:** occurs when `valid & ready`.
  - The data byte is latched into the shift register.
  - `grant_id` and `last_grant` are set to the granted id.
  - State moves to START.
- **Requester rules:**
  - A requester holds valid and data stable until its ready is seen.
  - Dropping valid before transfer withdraws the request; no error is raised.
- **Bit sequencing:**
  - START drives `tx=0` for one bit period.
  - DATA drives shift register bit 0, shifting right on each tick, for 8 ticks. A 3-bit bit index counts 0..7; the tick at index 7 leaves DATA.
  - PARITY is present only when configured (see Configuration).
  - STOP drives `tx=1` for one bit period, then returns to IDLE.
- **tx:** registered; holds 1 in IDLE.
- **Reset:** applies in any state, including mid-frame, and takes effect at the next clk edge:
  - state IDLE, counter 0, shift register 0, bit index 0.
  - `tx=1`, `busy=0`, `grant_id=0`, `last_grant=1`, both readys 0.
  - Any partial frame is aborted, not resumed.

## Timing
- Transfer at edge k: `tx` falls and `busy` rises after edge k.
- Each bit lasts exactly PERIOD clk cycles.
- Frame length: 10·PERIOD cycles (11·PERIOD with parity), measured from edge k to STOP exit.
- After STOP exit, at least one IDLE cycle elapses before the next transfer, so the minimum inter-frame gap is 1 clk of idle-high beyond the stop bit.
- Valid asserted while busy is accepted on the first IDLE cycle after the frame ends.
- Simultaneous valid0 and valid1 are served alternately, so neither requester waits more than one frame.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state follows DATA and drives even parity (XOR of the 8 latched data bits) for one bit period.
  - Frame is 11·PERIOD cycles.
- Undefined: no PARITY state; DATA goes directly to STOP; frame is 10·PERIOD cycles.

## Test plan
- **Single byte:** PERIOD=4, no parity; valid0=1, data0=0x55 from IDLE.
  - ready0 is high for exactly 1 cycle.
  - `tx` shows 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles (40 cycles total), then stays 1.
  - `busy` is high for 40 cycles; `grant_id`=0.
- **Contention:** valid0 and valid1 held high continuously, data0=0xA0, data1=0x0B.
  - Frames alternate 0xA0, 0x0B, 0xA0; `grant_id` toggles 0,1,0.
  - Ready never asserts during a frame.
- **Reset mid-frame:** Reset pulsed for 1 cycle during DATA bit 3.
  - Next cycle: `tx=1`, `busy=0`, `grant_id=0`.
  - A new valid1 with 0xFF transmits a full clean frame.
- **Parity:** `UART_TX_PARITY_EN` defined, data0=0x07.
  - Parity bit = 1; frame is 44 cycles at PERIOD=4.
  - With data0=0x03 the parity bit = 0.
- **Back-to-back single requester:** valid1 held high with 3 successive bytes.
  - Exactly 1 idle-high clk separates consecutive stop-bit ends from the next start bit.
  - Baud counter restarts at 0 for each frame.
- **Withdrawn request:** valid0 pulsed for 1 cycle while busy.
  - No extra frame is sent.
  - ready0 never asserts.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: transmit controller for the POV serial link.
// Sequences 8N1 UART frames (start, 8 data bits LSB-first, stop) onto tx and
// shares the line between two byte requesters with round-robin arbitration.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after DATA.
module uart_tx_scheduler #(
  parameter int PERIOD = 5208,
  parameter int CNT_W  = 13
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [7:0] data0,
  input  logic       valid0,
  output logic       ready0,
  input  logic [7:0] data1,
  input  logic       valid1,
  output logic       ready1,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic [2:0]       bitidx, bitidx_n;
  logic             tx_n;
  logic             grant_n;
  logic             last_grant, last_n;
  logic             granted;
  logic             idle;
  logic             tick;
  logic [7:0]       sel_data;
`ifdef UART_TX_PARITY_EN
  logic             par, par_n;
`endif

  assign idle = (state == IDLE);
  assign busy = ~idle;
  assign tick = ~idle && (cnt == CNT_W'(PERIOD - 1));

  // Round-robin pick and ready generation; ready is suppressed while Reset is high
  always_comb begin
    granted = 1'b0;
    if (valid0 && valid1) begin
      granted = ~last_grant;
    end else if (valid1) begin
      granted = 1'b1;
    end
    sel_data = granted ? data1 : data0;
    ready0   = ~Reset && idle && valid0 && ~granted;
    ready1   = ~Reset && idle && valid1 && granted;
  end

  // Next-state, baud counter, shifter and next tx level for the frame sequencer
  always_comb begin
    state_n  = state;
    cnt_n    = tick ? '0 : cnt + CNT_W'(1);
    shreg_n  = shreg;
    bitidx_n = bitidx;
    tx_n     = tx;
    grant_n  = grant_id;
    last_n   = last_grant;
`ifdef UART_TX_PARITY_EN
    par_n    = par;
`endif
    case (state)
      IDLE: begin
        cnt_n    = '0;
        tx_n     = 1'b1;
        bitidx_n = 3'd0;
        if (ready0 || ready1) begin
          shreg_n = sel_data;
          grant_n = granted;
          last_n  = granted;
          state_n = START;
          tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_n   = ^sel_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n = shreg >> 1;
          if (bitidx == 3'd7) begin
            bitidx_n = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_n  = PARITY;
            tx_n     = par;
`else
            state_n  = STOP;
            tx_n     = 1'b1;
`endif
          end else begin
            bitidx_n = bitidx + 3'd1;
            tx_n     = shreg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

  // State register; Reset aborts any frame in progress at the next edge
  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      bitidx     <= '0;
      tx         <= 1'b1;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      bitidx     <= bitidx_n;
      tx         <= tx_n;
      grant_id   <= grant_n;
      last_grant <= last_n;
`ifdef UART_TX_PARITY_EN
      par        <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed plus randomized bench for uart_tx_scheduler.
// The expected line waveform is built from the frame format itself: bit slot
// j of a frame is start/data/[parity]/stop, each slot PERIOD clocks long.
module tb_uart_tx_scheduler;

  localparam int P = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic       tx, busy, grant_id;

  int   total = 0;
  int   bad   = 0;
  logic last_grant_m = 1'b1;

  uart_tx_scheduler #(.PERIOD(P), .CNT_W(3)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .data0    (data0),
    .valid0   (valid0),
    .ready0   (ready0),
    .data1    (data1),
    .valid1   (valid1),
    .ready1   (ready1),
    .tx       (tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // Expected line level for bit slot j of a frame carrying byte b
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1);
    valid0 = v0;
    data0  = d0;
    valid1 = v1;
    data1  = d1;
  endtask

  // Called at a negedge with the DUT idle and inputs already driven.
  // Checks the accept cycle and then nCyc (0 = whole frame) cycles of the frame.
  task automatic runFrame(input logic v0a, input logic v1a,
                          input logic [7:0] d0a, input logic [7:0] d1a,
                          input int n_cyc, input int pulse0_at);
    logic       id;
    logic [7:0] b;
    int         lim;
    id = (valid0 && valid1) ? ~last_grant_m : valid1;
    b  = id ? data1 : data0;
    #1;
    checkOutput("accept_tx", tx, 1'b1);
    checkOutput("accept_busy", busy, 1'b0);
    checkOutput("accept_ready0", ready0, id == 1'b0);
    checkOutput("accept_ready1", ready1, id == 1'b1);
    last_grant_m = id;
    @(posedge clk);
    @(negedge clk);
    applyStimulus(v0a, d0a, v1a, d1a);
    lim = (n_cyc > 0) ? n_cyc : FB * P;
    for (int i = 0; i < lim; i++) begin
      if (i == pulse0_at) valid0 = 1'b1;
      else if (pulse0_at >= 0 && i == pulse0_at + 1) valid0 = 1'b0;
      #1;
      checkOutput($sformatf("frame_tx[%0d] byte=%02h", i, b), tx, exp_bit(b, i / P));
      checkOutput($sformatf("frame_busy[%0d]", i), busy, 1'b1);
      checkOutput($sformatf("frame_ready0[%0d]", i), ready0, 1'b0);
      checkOutput($sformatf("frame_ready1[%0d]", i), ready1, 1'b0);
      checkOutput($sformatf("frame_grant[%0d]", i), grant_id, id);
      @(negedge clk);
    end
  endtask

  // Line must stay idle-high with no acceptance for n cycles
  task automatic idleCheck(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput("idle_tx", tx, 1'b1);
      checkOutput("idle_busy", busy, 1'b0);
      checkOutput("idle_ready0", ready0, 1'b0);
      checkOutput("idle_ready1", ready1, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic resetChecks(input string tag);
    checkOutput({tag, "_tx"}, tx, 1'b1);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_grant"}, grant_id, 1'b0);
    checkOutput({tag, "_ready0"}, ready0, 1'b0);
    checkOutput({tag, "_ready1"}, ready1, 1'b0);
  endtask

  initial begin
    logic [7:0] b1, b2, b3;
    logic       rv0, rv1;
    Reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    #1;
    resetChecks("reset");
    @(negedge clk);

    $display("[TB] single byte 0x55 from requester 0");
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00);
    runFrame(1'b0, 1'b0, 8'h00, 8'h00, 0, -1);
    idleCheck(2 * P);

    $display("[TB] reset during data bit 3");
    applyStimulus(1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'h00);
    runFrame(1'b0, 1'b0, 8'h00, 8'h00, 4 * P + 2, -1);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    #1;
    resetChecks("midreset");
    last_grant_m = 1'b1;
    @(negedge clk);
    idleCheck(2 * P);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hFF);
    runFrame(1'b0, 1'b0, 8'h00, 8'h00, 0, -1);
    idleCheck(P);

    $display("[TB] contention, both requesters held");
    applyStimulus(1'b1, 8'hA0, 1'b1, 8'h0B);
    runFrame(1'b1, 1'b1, 8'hA0, 8'h0B, 0, -1);
    runFrame(1'b1, 1'b1, 8'hA0, 8'h0B, 0, -1);
    runFrame(1'b0, 1'b0, 8'h00, 8'h00, 0, -1);
    idleCheck(P);

    $display("[TB] parity-sensitive bytes");
    applyStimulus(1'b1, 8'h07, 1'b0, 8'h00);
    runFrame(1'b0, 1'b0, 8'h00, 8'h00, 0, -1);
    applyStimulus(1'b1, 8'h03, 1'b0, 8'h00);
    runFrame(1'b0, 1'b0, 8'h00, 8'h00, 0, -1);
    idleCheck(P);

    $display("[TB] back-to-back from requester 1");
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    b3 = 8'($urandom_range(0, 255));
    applyStimulus(1'b0, 8'h00, 1'b1, b1);
    runFrame(1'b0, 1'b1, 8'h00, b2, 0, -1);
    runFrame(1'b0, 1'b1, 8'h00, b3, 0, -1);
    runFrame(1'b0, 1'b0, 8'h00, 8'h00, 0, -1);
    idleCheck(P);

    $display("[TB] withdrawn request while busy");
    applyStimulus(1'b0, 8'h00, 1'b1, 8'($urandom_range(0, 255)));
    runFrame(1'b0, 1'b0, 8'h3C, 8'h00, 0, 3 * P + 1);
    idleCheck(3 * P);

    $display("[TB] randomized requests");
    for (int k = 0; k < 8; k++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(rv0, 8'($urandom_range(0, 255)), rv1, 8'($urandom_range(0, 255)));
      runFrame(1'b0, 1'b0, 8'h00, 8'h00, 0, -1);
    end
    idleCheck(P);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
